// File: rtl/alu_pipe_pkg.sv
// Shared opcode classes, FSM state encoding and flag bundle for alu_pipe.
package alu_pipe_pkg;

    localparam logic [3:0] OP_SHIFT = 4'b0000;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_NEG   = 4'b1011;
    localparam logic [3:0] OP_ADD   = 4'b1100;
    localparam logic [3:0] OP_ADC   = 4'b1101;
    localparam logic [3:0] OP_SUB   = 4'b1110;
    localparam logic [3:0] OP_SBC   = 4'b1111;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_ASR = 2'b01;
    localparam logic [1:0] SH_ROL = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Unsigned W x W shift-add multiplier: one partial product per cycle, W cycles after start.
// done is high during the final step; prod already includes that step's partial product.
module alu_pipe_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);
    import alu_pipe_pkg::*;

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0]  count_reg;
    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] mcand_reg;
    logic [W-1:0]   mplier_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            count_reg  <= CW'(W);
            acc_reg    <= '0;
            mcand_reg  <= {{W{1'b0}}, a};
            mplier_reg <= b;
        end else if (count_reg != '0) begin
            count_reg  <= count_reg - CW'(1);
            acc_reg    <= prod;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
        end
    end

    assign prod = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign done = (count_reg == CW'(1));

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: one-cycle logic/shift/add ops, W-cycle multiply, results held until accepted.
// Define ALU_PIPE_OVF_EN to drive vo with signed overflow; otherwise vo stays 0.
module alu_pipe #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     op,
    input  logic [W-1:0]   rd,
    input  logic [W-1:0]   rr,
    input  logic           ci,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] res,
    output logic           co,
    output logic           no,
    output logic           zo,
    output logic           vo,
    output logic           err
);
    import alu_pipe_pkg::*;

    state_t         state_reg, state_next;
    logic [2*W-1:0] res_reg;
    flags_t         flags_reg;
    logic           err_reg;

    logic [3:0]     cls;
    logic [1:0]     sub;
    logic           unused_op_bits;
    logic           is_mul, sub_path, accept;
    logic           mul_start, mul_done, load_alu, load_mul;
    logic [2*W-1:0] mul_prod;
    flags_t         mul_flags;
    logic [W-1:0]   add_a, add_b;
    logic           add_cin;
    logic [W:0]     sum;
    logic [W-1:0]   alu_res;
    flags_t         alu_flags;
    logic           alu_err;

    assign cls            = op[7:4];
    assign sub            = op[1:0];
    assign unused_op_bits = &op[3:2];
    assign is_mul         = (cls == OP_MUL);

    // Subtraction and negation share the adder as a + ~b + carry-in; borrow is the inverted carry.
    assign sub_path = (cls == OP_SUB) || (cls == OP_SBC) || (cls == OP_NEG);
    assign add_a    = (cls == OP_NEG) ? '0 : rd;
    assign add_b    = (cls == OP_NEG) ? ~rd : (sub_path ? ~rr : rr);

    always_comb begin
        case (cls)
            OP_ADC:         add_cin = ci;
            OP_SUB, OP_NEG: add_cin = 1'b1;
            OP_SBC:         add_cin = ~ci;
            default:        add_cin = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        alu_err   = 1'b0;
        case (cls)
            OP_SHIFT: begin
                case (sub)
                    SH_LSL: begin alu_res = {rd[W-2:0], 1'b0};   alu_flags.c = rd[W-1]; end
                    SH_ASR: begin alu_res = {rd[W-1], rd[W-1:1]}; alu_flags.c = rd[0];   end
                    SH_ROL: begin alu_res = {rd[W-2:0], ci};     alu_flags.c = rd[W-1]; end
                    default: begin alu_res = {ci, rd[W-1:1]};    alu_flags.c = rd[0];   end
                endcase
            end
            OP_AND: alu_res = rd & rr;
            OP_OR:  alu_res = rd | rr;
            OP_XOR: alu_res = rd ^ rr;
            OP_NEG: begin
                if (sub == 2'b00) begin
                    alu_res     = sum[W-1:0];
                    alu_flags.c = ~sum[W];
                end else begin
                    alu_err = 1'b1;
                end
            end
            OP_ADD, OP_ADC: begin
                alu_res     = sum[W-1:0];
                alu_flags.c = sum[W];
            end
            OP_SUB, OP_SBC: begin
                alu_res     = sum[W-1:0];
                alu_flags.c = ~sum[W];
            end
            OP_MUL: ;
            default: alu_err = 1'b1;
        endcase
        if (!alu_err) begin
            alu_flags.n = alu_res[W-1];
            alu_flags.z = (alu_res == '0);
        end
`ifdef ALU_PIPE_OVF_EN
        if (!alu_err && ((cls[3:2] == 2'b11) || (cls == OP_NEG)))
            alu_flags.v = (add_a[W-1] == add_b[W-1]) && (sum[W-1] != add_a[W-1]);
        else if ((cls == OP_SHIFT) && !sub[0])
            alu_flags.v = rd[W-1] ^ alu_res[W-1];
`endif
    end

    alu_pipe_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (rd),
        .b     (rr),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        mul_flags   = '0;
        mul_flags.c = mul_prod[2*W-1];
        mul_flags.z = (mul_prod == '0);
    end

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        load_alu   = 1'b0;
        load_mul   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if ((state_reg == DONE) && out_ready)
                    state_next = IDLE;
                if (accept) begin
                    if (is_mul) begin
                        state_next = MUL;
                        mul_start  = 1'b1;
                    end else begin
                        state_next = DONE;
                        load_alu   = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = DONE;
                    load_mul   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only load on a completion, so nothing partial is ever presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            res_reg   <= '0;
            flags_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_alu) begin
                res_reg   <= {{W{1'b0}}, alu_res};
                flags_reg <= alu_flags;
                err_reg   <= alu_err;
            end else if (load_mul) begin
                res_reg   <= mul_prod;
                flags_reg <= mul_flags;
                err_reg   <= 1'b0;
            end
        end
    end

    assign res = res_reg;
    assign co  = flags_reg.c;
    assign no  = flags_reg.n;
    assign zo  = flags_reg.z;
    assign vo  = flags_reg.v;
    assign err = err_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (W=8): directed cases plus random traffic, checked every cycle against
// an arithmetic reference model and a queue of outstanding results.
module tb_alu_pipe;
    localparam int     W     = 8;
    localparam longint FULLR = longint'(1) << W;
    localparam longint HALF  = longint'(1) << (W - 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     op;
    logic [W-1:0]   rd;
    logic [W-1:0]   rr;
    logic           ci;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] res;
    logic           co, no, zo, vo, err;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2*W-1:0] res;
        logic c, n, z, v, e;
        int lat;
        int due;
    } exp_t;

    exp_t q[$];

    alu_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rr        (rr),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .co        (co),
        .no        (no),
        .zo        (zo),
        .vo        (vo),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input logic [7:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t   x;
        longint ua, ub, uc, sa, sb, r, s;
        bit     legal, arith, shl;
        ua = longint'(a);
        ub = longint'(b);
        uc = cin ? 64'sd1 : 64'sd0;
        sa = (ua >= HALF) ? ua - FULLR : ua;
        sb = (ub >= HALF) ? ub - FULLR : ub;
        x.res = '0; x.c = 0; x.n = 0; x.z = 0; x.v = 0; x.e = 0; x.lat = 1; x.due = 0;
        r = 0; s = 0; legal = 1; arith = 0; shl = 0;
        case (o[7:4])
            4'h0: begin
                case (o[1:0])
                    2'd0:    begin r = ua * 2;                           x.c = (ua >= HALF); shl = 1; end
                    2'd1:    begin r = ua / 2 + ((ua >= HALF) ? HALF : 0); x.c = (ua % 2) != 0; end
                    2'd2:    begin r = ua * 2 + uc;                      x.c = (ua >= HALF); shl = 1; end
                    default: begin r = ua / 2 + uc * HALF;               x.c = (ua % 2) != 0; end
                endcase
            end
            4'h4: begin
                r     = ua * ub;
                x.res = (2*W)'(r);
                x.c   = x.res[2*W-1];
                x.z   = (r == 0);
                x.lat = W + 1;
                return x;
            end
            4'h8: r = ua & ub;
            4'h9: r = ua | ub;
            4'hA: r = ua ^ ub;
            4'hB: begin
                if (o[1:0] == 2'd0) begin r = -ua; s = -sa; x.c = (ua != 0); arith = 1; end
                else legal = 0;
            end
            4'hC, 4'hD: begin
                r = ua + ub + (o[4] ? uc : 0);
                s = sa + sb + (o[4] ? uc : 0);
                x.c = (r >= FULLR); arith = 1;
            end
            4'hE, 4'hF: begin
                r = ua - ub - (o[4] ? uc : 0);
                s = sa - sb - (o[4] ? uc : 0);
                x.c = (r < 0); arith = 1;
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            x.e = 1;
            return x;
        end
        r     = ((r % FULLR) + FULLR) % FULLR;
        x.res = (2*W)'(r);
        x.n   = (r >= HALF);
        x.z   = (r == 0);
`ifdef ALU_PIPE_OVF_EN
        if (arith) x.v = (s >= HALF) || (s < -HALF);
        if (shl)   x.v = (ua >= HALF) != (r >= HALF);
`else
        if (arith || shl) x.v = 0;
`endif
        return x;
    endfunction

    // Single compare process: retire on transfer first, then enqueue a newly accepted op.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_valid, exp_ready;
        if (rst) begin
            q.delete();
        end else begin
            exp_valid = (q.size() != 0) && (cyc >= q[0].due);
            exp_ready = (q.size() == 0) || (exp_valid && out_ready);
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, exp_ready);
            if (exp_valid && out_valid) begin
                chk("res", res, q[0].res);
                chk("co", co, q[0].c);
                chk("no", no, q[0].n);
                chk("zo", zo, q[0].z);
                chk("vo", vo, q[0].v);
                chk("err", err, q[0].e);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e     = model(op, rd, rr, ci);
                e.due = cyc + e.lat;
                q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
        int n;
        n = 0;
        op = o; rd = a; rr = b; ci = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        exp_t m;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rd = '0; rr = '0; ci = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res", res, 0);
        chk("rst_flags", {co, no, zo, vo, err}, 0);

        // Pin the model with hand-computed values.
        m = model(8'hC0, 8'hFF, 8'h01, 1'b0);
        chk("pin_add", {m.res, m.c, m.n, m.z, m.v, m.e}, {16'h0000, 5'b10100});
        m = model(8'hF0, 8'h10, 8'h10, 1'b1);
        chk("pin_sbc", {m.res, m.c, m.n, m.z, m.v, m.e}, {16'h00FF, 5'b11000});
        m = model(8'h40, 8'hFF, 8'hFF, 1'b0);
        chk("pin_mul", {m.res, m.c, m.z, m.n}, {16'hFE01, 3'b100});
        chk("pin_mul_lat", m.lat, 9);
        m = model(8'h03, 8'h01, 8'h00, 1'b1);
        chk("pin_ror", {m.res, m.c, m.n, m.z}, {16'h0080, 3'b110});
        m = model(8'h01, 8'h81, 8'h00, 1'b0);
        chk("pin_asr", {m.res, m.c}, {16'h00C0, 1'b1});
        m = model(8'h20, 8'h12, 8'h34, 1'b1);
        chk("pin_illegal", {m.res, m.c, m.n, m.z, m.v, m.e}, {16'h0000, 5'b00001});

        @(posedge clk); #1;
        send(8'hC0, 8'hFF, 8'h01, 1'b0);
        send(8'hF0, 8'h10, 8'h10, 1'b1);
        send(8'h40, 8'hFF, 8'hFF, 1'b0);
        repeat (12) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(8'h03, 8'h01, 8'h00, 1'b1);
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;

        send(8'h80, 8'h3C, 8'h0F, 1'b0);
        send(8'hA0, 8'hAA, 8'hAA, 1'b0);
        send(8'h01, 8'h80, 8'h00, 1'b1);
        send(8'h20, 8'h55, 8'h66, 1'b1);
        send(8'hB0, 8'h80, 8'h00, 1'b0);
        send(8'hB1, 8'h01, 8'h00, 1'b0);
        @(posedge clk); #1;

        send(8'h40, 8'h5A, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midmul_rst_out_valid", out_valid, 0);
        chk("midmul_rst_res", res, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_res", res, 0);
        chk("post_rst_flags", {co, no, zo, vo, err}, 0);
        repeat (12) @(posedge clk);
        #1;

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 8'($urandom);
            rd        = ($urandom_range(0, 5) == 0) ? {W{1'b1}} : W'($urandom);
            rr        = ($urandom_range(0, 5) == 0) ? {W{1'b0}} : W'($urandom);
            ci        = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
